// File: rtl/fpga_lut_cfg_loader.sv
// Byte-stream loader that assembles 16-bit truth tables and writes them one by one into the fabric LUTs.
// Define FPGA_CFG_CHECKSUM_EN to require a trailing XOR checksum byte before the fabric is enabled.
module fpga_lut_cfg_loader #(
   parameter int unsigned NUM_LUTS   = 8,
   parameter logic [7:0]  START_BYTE = 8'hA5
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                cfg_valid_i,
   input  logic [7:0]          cfg_data_i,
   output logic                cfg_ready_o,
   input  logic                clear_i,
   output logic [15:0]         lut_data_o,
   output logic [NUM_LUTS-1:0] lut_we_o,
   output logic                fabric_en_o,
   output logic                err_o
);
   localparam int unsigned IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

   typedef enum logic [2:0] {
      IDLE, CNT, LO, HI, WRITE, DONE, ERR
`ifdef FPGA_CFG_CHECKSUM_EN
      , CHK
`endif
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] index;
   logic [7:0]       count;
   logic             accept;

   // WRITE is the only cycle where the stream is stalled
   assign cfg_ready_o = (state != WRITE);
   assign accept      = cfg_valid_i && cfg_ready_o;

`ifdef FPGA_CFG_CHECKSUM_EN
   logic [7:0] csum;

   // Running XOR over the count byte and all data bytes of the current frame
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         csum <= '0;
      end else if (accept) begin
         if ((state == IDLE || (state == DONE && !clear_i)) && cfg_data_i == START_BYTE)
            csum <= '0;
         else if (state == CNT || state == LO || state == HI)
            csum <= csum ^ cfg_data_i;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state       <= IDLE;
         lut_data_o  <= '0;
         lut_we_o    <= '0;
         fabric_en_o <= 1'b0;
         err_o       <= 1'b0;
         index       <= '0;
         count       <= '0;
      end else begin
         lut_we_o <= '0;
         case (state)
            IDLE: begin
               if (accept && cfg_data_i == START_BYTE) state <= CNT;
            end
            CNT: begin
               if (accept) begin
                  if (cfg_data_i == 8'd0 || 32'(cfg_data_i) > NUM_LUTS) begin
                     state <= ERR;
                     err_o <= 1'b1;
                  end else begin
                     count <= cfg_data_i;
                     index <= '0;
                     state <= LO;
                  end
               end
            end
            LO: begin
               if (accept) begin
                  lut_data_o[7:0] <= cfg_data_i;
                  state           <= HI;
               end
            end
            HI: begin
               // Pulse is registered so it lines up exactly with the WRITE cycle
               if (accept) begin
                  lut_data_o[15:8] <= cfg_data_i;
                  lut_we_o         <= NUM_LUTS'(1) << index;
                  state            <= WRITE;
               end
            end
            WRITE: begin
               index <= index + IDX_W'(1);
               count <= count - 8'd1;
               if (count != 8'd1) begin
                  state <= LO;
               end else begin
`ifdef FPGA_CFG_CHECKSUM_EN
                  state <= CHK;
`else
                  state       <= DONE;
                  fabric_en_o <= 1'b1;
`endif
               end
            end
`ifdef FPGA_CFG_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  if (cfg_data_i == csum) begin
                     state       <= DONE;
                     fabric_en_o <= 1'b1;
                  end else begin
                     state <= ERR;
                     err_o <= 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               if (clear_i) begin
                  state       <= IDLE;
                  fabric_en_o <= 1'b0;
               end else if (accept && cfg_data_i == START_BYTE) begin
                  state       <= CNT;
                  fabric_en_o <= 1'b0;
               end
            end
            ERR: begin
               if (clear_i) begin
                  state <= IDLE;
                  err_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpga_lut_cfg_loader.sv
// Directed bench for fpga_lut_cfg_loader: frame loads, dropped bytes, count errors, gaps, mid-frame reset.
// Sends the trailing checksum byte when FPGA_CFG_CHECKSUM_EN is defined.
module tb_fpga_lut_cfg_loader;
   localparam int unsigned NUM_LUTS = 8;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                cfg_valid;
   logic [7:0]          cfg_data;
   logic                cfg_ready;
   logic                clear;
   logic [15:0]         lut_data;
   logic [NUM_LUTS-1:0] lut_we;
   logic                fabric_en;
   logic                err;

   int passed = 0;
   int total  = 0;
   int bad_cycles = 0;
   bit mon_en = 1'b0;

   logic [NUM_LUTS-1:0] we_log[$];
   logic [15:0]         data_log[$];

   fpga_lut_cfg_loader #(.NUM_LUTS(NUM_LUTS), .START_BYTE(8'hA5)) dut (
      .clk_i(clk), .reset_ni(reset_n), .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data),
      .cfg_ready_o(cfg_ready), .clear_i(clear), .lut_data_o(lut_data), .lut_we_o(lut_we),
      .fabric_en_o(fabric_en), .err_o(err)
   );

   always #5 clk = ~clk;

   // Log each write cycle; flag non-one-hot pulses and ready not being the inverse of a write
   always @(negedge clk) begin
      if (mon_en) begin
         if (lut_we !== '0) begin
            we_log.push_back(lut_we);
            data_log.push_back(lut_data);
            if ($countones(lut_we) != 1) bad_cycles++;
         end
         if (cfg_ready !== (lut_we == '0)) bad_cycles++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int t = 0;
      cfg_valid = 1'b0;
      repeat (gap) @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = b;
      while (!cfg_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk("ready_timeout", 32'(t), 32'd0);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Sends the frame (optionally with random gaps) and, when enabled, its checksum byte
   task automatic send_frame(input logic [7:0] q[$], input bit gaps, input logic [7:0] csum_flip);
      logic [7:0] x = 8'h00;
      foreach (q[i]) begin
         if (i > 0) x ^= q[i];
         send(q[i], gaps ? int'($urandom_range(0, 3)) : 0);
      end
`ifdef FPGA_CFG_CHECKSUM_EN
      send(x ^ csum_flip, gaps ? int'($urandom_range(0, 3)) : 0);
`else
      x = x ^ csum_flip;
`endif
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_we"}, 32'(lut_we), 32'd0);
      chk({tag, "_data"}, 32'(lut_data), 32'd0);
      chk({tag, "_fen"}, 32'(fabric_en), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] q[$];
      reset_n = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; clear = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);

      // Two-LUT frame, back to back
      q = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
      send_frame(q, 1'b0, 8'h00);
      chk("t1_nwr", 32'(we_log.size()), 32'd2);
      if (we_log.size() == 2) begin
         chk("t1_we0", 32'(we_log[0]), 32'h01);
         chk("t1_d0", 32'(data_log[0]), 32'h1234);
         chk("t1_we1", 32'(we_log[1]), 32'h02);
         chk("t1_d1", 32'(data_log[1]), 32'hABCD);
      end
      chk("t1_fen", 32'(fabric_en), 32'd1);
      chk("t1_err", 32'(err), 32'd0);

      // Clear from DONE, then leading junk bytes are dropped in IDLE
      pulse_clear();
      chk("t2_clr_fen", 32'(fabric_en), 32'd0);
      we_log.delete(); data_log.delete();
      send(8'h00, 0);
      send(8'hFF, 1);
      q = '{8'hA5, 8'h01, 8'h0F, 8'hF0};
      send_frame(q, 1'b0, 8'h00);
      chk("t2_nwr", 32'(we_log.size()), 32'd1);
      if (we_log.size() == 1) begin
         chk("t2_we0", 32'(we_log[0]), 32'h01);
         chk("t2_d0", 32'(data_log[0]), 32'hF00F);
      end
      chk("t2_fen", 32'(fabric_en), 32'd1);

      // Count above NUM_LUTS errors out; ERR still consumes bytes; clear recovers
      pulse_clear();
      we_log.delete(); data_log.delete();
      send(8'hA5, 0);
      send(8'h09, 0);
      @(negedge clk);
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_fen", 32'(fabric_en), 32'd0);
      send(8'h5A, 0);
      chk("t3_err_hold", 32'(err), 32'd1);
      chk("t3_nwr", 32'(we_log.size()), 32'd0);
      pulse_clear();
      chk("t3_clr_err", 32'(err), 32'd0);

      // Zero count also errors out
      send(8'hA5, 0);
      send(8'h00, 0);
      @(negedge clk);
      chk("t3b_err_zero", 32'(err), 32'd1);
      pulse_clear();

      // Full-size frame: every LUT index gets its own one-hot pulse
      q = '{8'hA5, 8'h08};
      for (int k = 0; k < 8; k++) begin
         q.push_back(8'h10 + 8'(k));
         q.push_back(8'hC0 + 8'(k));
      end
      send_frame(q, 1'b0, 8'h00);
      chk("t8_nwr", 32'(we_log.size()), 32'd8);
      if (we_log.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            logic [7:0] hot;
            hot = 8'd1 << k;
            chk($sformatf("t8_we%0d", k), 32'(we_log[k]), 32'(hot));
            chk($sformatf("t8_d%0d", k), 32'(data_log[k]), {16'h0, 8'hC0 + 8'(k), 8'h10 + 8'(k)});
         end
      end
      chk("t8_fen", 32'(fabric_en), 32'd1);

      // Reconfigure from DONE with random valid gaps
      we_log.delete(); data_log.delete();
      send(8'hA5, 0);
      chk("t4_reconf_fen", 32'(fabric_en), 32'd0);
      q = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
      foreach (q[i]) send(q[i], int'($urandom_range(0, 3)));
`ifdef FPGA_CFG_CHECKSUM_EN
      send(8'h42, int'($urandom_range(0, 3)));
`endif
      repeat (2) @(negedge clk);
      chk("t4_nwr", 32'(we_log.size()), 32'd2);
      if (we_log.size() == 2) begin
         chk("t4_we0", 32'(we_log[0]), 32'h01);
         chk("t4_d0", 32'(data_log[0]), 32'h1234);
         chk("t4_we1", 32'(we_log[1]), 32'h02);
         chk("t4_d1", 32'(data_log[1]), 32'hABCD);
      end
      chk("t4_fen", 32'(fabric_en), 32'd1);

      // Reset in the middle of a three-LUT frame
      pulse_clear();
      we_log.delete(); data_log.delete();
      send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_nwr", 32'(we_log.size()), 32'd1);
      if (we_log.size() == 1) chk("t5_d0", 32'(data_log[0]), 32'h2211);
      check_idle_outputs("t5_rst");
      reset_n = 1'b1;
      @(negedge clk);
      we_log.delete(); data_log.delete();
      q = '{8'hA5, 8'h01, 8'h0F, 8'hF0};
      send_frame(q, 1'b1, 8'h00);
      chk("t5_nwr_after", 32'(we_log.size()), 32'd1);
      if (we_log.size() == 1) chk("t5_d_after", 32'(data_log[0]), 32'hF00F);
      chk("t5_fen", 32'(fabric_en), 32'd1);

`ifdef FPGA_CFG_CHECKSUM_EN
      // Bad checksum: writes still happen but the fabric stays disabled
      pulse_clear();
      we_log.delete(); data_log.delete();
      q = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
      send_frame(q, 1'b0, 8'h01);
      chk("t6_nwr", 32'(we_log.size()), 32'd2);
      chk("t6_err", 32'(err), 32'd1);
      chk("t6_fen", 32'(fabric_en), 32'd0);
      pulse_clear();
      send_frame(q, 1'b0, 8'h00);
      chk("t6_good_fen", 32'(fabric_en), 32'd1);
      chk("t6_good_err", 32'(err), 32'd0);
`endif

      chk("ready_we_consistency", 32'(bad_cycles), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
